rsa_keygen: RTL and testbench

Computes an RSA key pair from primes p, q and public exponent e: n = p·q, φ = (p−1)(q−1), and private exponent d = e⁻¹ mod φ via iterative extended Euclid. It produces the 12-bit n and d consumed by the modular-exponentiation decrypt/encrypt datapath. It is sequential and one-shot per start. A shared restoring divider keeps the area small.

---
 rtl/rsa_pkg.sv | 21 ++
 rtl/rsa_div.sv | 69 ++++++
 rtl/rsa_keygen.sv | 203 ++++++++++++++++++++
 tb/tb_rsa_keygen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared widths, FSM state encoding and the signed Bezout-coefficient type
// for the RSA key generator.
package rsa_pkg;

    localparam int P_W_DEF = 6;
    localparam int N_W_DEF = 2 * P_W_DEF;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        DIV,
        UPDATE,
        CHECK,
        VERIFY,
        DONE,
        ERR
    } state_t;

    typedef logic signed [N_W_DEF:0] t_t;

endpackage

// File: rtl/rsa_div.sv
// Restoring unsigned divider: one load cycle, then W shift/subtract steps.
// dividend_hi seeds the partial remainder so a 2W-bit dividend can be reduced.
module rsa_div
    import rsa_pkg::*;
#(
    parameter int W = N_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend_hi,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_reg;
    logic [W-1:0]  quo_reg;
    logic [W-1:0]  dsr_reg;
    logic [CW-1:0] cnt_reg;
    logic          run_reg;
    logic          done_reg;

    logic [W:0]    shifted;
    logic          fits;
    logic [W-1:0]  diff;

    // Partial remainder stays below the divisor, so shifted fits in W+1 bits
    // and the true difference always fits in W bits.
    assign shifted = {rem_reg, quo_reg[W-1]};
    assign fits    = shifted >= {1'b0, dsr_reg};
    assign diff    = shifted[W-1:0] - dsr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg  <= '0;
            quo_reg  <= '0;
            dsr_reg  <= '0;
            cnt_reg  <= '0;
            run_reg  <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                rem_reg <= dividend_hi;
                quo_reg <= dividend;
                dsr_reg <= divisor;
                cnt_reg <= CW'(W);
                run_reg <= 1'b1;
            end else if (run_reg) begin
                rem_reg <= fits ? diff : shifted[W-1:0];
                quo_reg <= {quo_reg[W-2:0], fits};
                cnt_reg <= cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    run_reg  <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done      = done_reg;
    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/rsa_keygen.sv
// RSA key pair generator: n = p*q and d = e^-1 mod phi by extended Euclid on a
// shared divider. Define RSA_KEYGEN_VERIFY_EN to add an (e*d) mod phi self-check.
module rsa_keygen
    import rsa_pkg::*;
#(
    parameter int  P_W = P_W_DEF,
    localparam int N_W = 2 * P_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [P_W-1:0] p,
    input  logic [P_W-1:0] q,
    input  logic [N_W-1:0] e,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [N_W-1:0] n_out,
    output logic [N_W-1:0] d_out
);
    typedef logic signed [N_W:0] tw_t;

    state_t         state_reg, state_next;
    logic [P_W-1:0] p_reg, q_reg;
    logic [N_W-1:0] e_reg, n_reg, phi_reg;
    logic [N_W-1:0] r0_reg, r1_reg, qt_reg, rm_reg;
    tw_t            t0_reg, t1_reg, t_new;
    logic [N_W-1:0] n_out_reg, d_out_reg;
    logic           err_reg;

    logic [N_W-1:0] n_calc, phi_calc, d_calc;
    logic           setup_bad;

    logic           div_start, div_done;
    logic [N_W-1:0] div_hi, div_a, div_b, div_q, div_r;

    assign n_calc    = N_W'(p_reg) * N_W'(q_reg);
    assign phi_calc  = (N_W'(p_reg) - N_W'(1)) * (N_W'(q_reg) - N_W'(1));
    assign setup_bad = (p_reg < P_W'(2)) || (q_reg < P_W'(2)) || (p_reg == q_reg) ||
                       (e_reg < N_W'(2)) || (e_reg >= phi_calc);

    // Coefficient update wraps to N_W+1 bits; |t| <= phi keeps it exact.
    assign t_new  = t0_reg - tw_t'({1'b0, qt_reg}) * t1_reg;
    assign d_calc = t0_reg[N_W] ? (t0_reg[N_W-1:0] + phi_reg) : t0_reg[N_W-1:0];

`ifdef RSA_KEYGEN_VERIFY_EN
    logic [2*N_W-1:0] ed_prod;
    logic [N_W-1:0]   d_reg;

    assign ed_prod = (2*N_W)'(e_reg) * (2*N_W)'(d_calc);
`endif

    rsa_div #(
        .W(N_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (div_start),
        .dividend_hi(div_hi),
        .dividend   (div_a),
        .divisor    (div_b),
        .done       (div_done),
        .quotient   (div_q),
        .remainder  (div_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The divider is launched on the edge that enters DIV/VERIFY, fed from the
    // values the Euclid registers are about to take.
    always_comb begin
        state_next = state_reg;
        div_start  = 1'b0;
        div_hi     = '0;
        div_a      = r1_reg;
        div_b      = rm_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = SETUP;
            end
            SETUP: begin
                if (setup_bad) begin
                    state_next = ERR;
                end else begin
                    state_next = DIV;
                    div_start  = 1'b1;
                    div_a      = phi_calc;
                    div_b      = e_reg;
                end
            end
            DIV: begin
                if (div_done) state_next = UPDATE;
            end
            UPDATE: begin
                if (rm_reg == '0) begin
                    state_next = CHECK;
                end else begin
                    state_next = DIV;
                    div_start  = 1'b1;
                end
            end
            CHECK: begin
                if (r0_reg != N_W'(1)) begin
                    state_next = ERR;
                end else begin
`ifdef RSA_KEYGEN_VERIFY_EN
                    state_next = VERIFY;
                    div_start  = 1'b1;
                    div_hi     = ed_prod[2*N_W-1:N_W];
                    div_a      = ed_prod[N_W-1:0];
                    div_b      = phi_reg;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef RSA_KEYGEN_VERIFY_EN
            VERIFY: begin
                if (div_done) state_next = (div_r == N_W'(1)) ? DONE : ERR;
            end
`endif
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg     <= '0;
            q_reg     <= '0;
            e_reg     <= '0;
            n_reg     <= '0;
            phi_reg   <= '0;
            r0_reg    <= '0;
            r1_reg    <= '0;
            qt_reg    <= '0;
            rm_reg    <= '0;
            t0_reg    <= '0;
            t1_reg    <= '0;
            n_out_reg <= '0;
            d_out_reg <= '0;
            err_reg   <= 1'b0;
`ifdef RSA_KEYGEN_VERIFY_EN
            d_reg     <= '0;
`endif
        end else begin
            if (state_reg == IDLE && start) begin
                p_reg <= p;
                q_reg <= q;
                e_reg <= e;
            end
            if (state_reg == SETUP) begin
                n_reg   <= n_calc;
                phi_reg <= phi_calc;
                r0_reg  <= phi_calc;
                r1_reg  <= e_reg;
                t0_reg  <= '0;
                t1_reg  <= tw_t'(1);
            end
            if (state_reg == DIV && div_done) begin
                qt_reg <= div_q;
                rm_reg <= div_r;
            end
            if (state_reg == UPDATE) begin
                r0_reg <= r1_reg;
                r1_reg <= rm_reg;
                t0_reg <= t1_reg;
                t1_reg <= t_new;
            end
`ifdef RSA_KEYGEN_VERIFY_EN
            if (state_reg == CHECK) d_reg <= d_calc;
`endif
            // Results are loaded on entry so they are valid in the done cycle.
            if (state_next == DONE) begin
                n_out_reg <= n_reg;
`ifdef RSA_KEYGEN_VERIFY_EN
                d_out_reg <= d_reg;
`else
                d_out_reg <= d_calc;
`endif
                err_reg   <= 1'b0;
            end else if (state_next == ERR) begin
                n_out_reg <= (state_reg == SETUP) ? n_calc : n_reg;
                d_out_reg <= '0;
                err_reg   <= 1'b1;
            end
        end
    end

    assign busy  = (state_reg != IDLE);
    assign done  = (state_reg == DONE) || (state_reg == ERR);
    assign err   = err_reg;
    assign n_out = n_out_reg;
    assign d_out = d_out_reg;

endmodule

// File: tb/tb_rsa_keygen.sv
// Scoreboard bench for rsa_keygen: expectations are queued at launch and
// matched against each done pulse, including latency.
module tb_rsa_keygen;
    localparam int P_W = 6;
    localparam int N_W = 12;
`ifdef RSA_KEYGEN_VERIFY_EN
    localparam int VLAT = N_W + 1;
`else
    localparam int VLAT = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [P_W-1:0] p = '0;
    logic [P_W-1:0] q = '0;
    logic [N_W-1:0] e = '0;
    logic           busy, done, err;
    logic [N_W-1:0] n_out, d_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int    n;
        int    d;
        int    er;
        int    lat;
        bit    n_chk;
        string tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    rsa_keygen #(.P_W(P_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .p    (p),
        .q    (q),
        .e    (e),
        .busy (busy),
        .done (done),
        .err  (err),
        .n_out(n_out),
        .d_out(d_out)
    );

    // Independent reference: brute-force inverse, plain Euclid step count.
    function automatic exp_t model(input int pp, input int qq, input int ee, input string tag);
        exp_t x;
        int   phi, a, b, r, k;
        bit   found;
        x.tag   = tag;
        x.n     = pp * qq;
        x.n_chk = 1'b1;
        phi     = (pp - 1) * (qq - 1);
        if (pp < 2 || qq < 2 || pp == qq || ee < 2 || ee >= phi) begin
            x.d = 0; x.er = 1; x.lat = 2; x.n_chk = 1'b0;
        end else begin
            k = 0; a = phi; b = ee;
            while (b != 0) begin
                r = a % b; a = b; b = r; k++;
            end
            found = 1'b0; x.d = 0;
            for (int i = 1; i < phi; i++) begin
                if (!found && ((ee * i) % phi) == 1) begin
                    x.d = i; found = 1'b1;
                end
            end
            x.er  = found ? 0 : 1;
            x.lat = 3 + 14 * k + (found ? VLAT : 0);
        end
        return x;
    endfunction

    task automatic push_const(input int nn, input int dd, input int er, input int lat,
                              input bit n_chk, input string tag);
        exp_t x;
        x.n = nn; x.d = dd; x.er = er; x.lat = lat; x.n_chk = n_chk; x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic launch(input int pp, input int qq, input int ee);
        @(negedge clk);
        p = P_W'(pp); q = P_W'(qq); e = N_W'(ee);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_cycle1: busy=%b, required 1", busy);
        end
    endtask

    task automatic sb_collect(input int cyc0, input bit poke);
        int   cyc;
        exp_t x;
        cyc = cyc0;
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL timeout: done=%b after %0d cycles, required 1", done, cyc);
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: done at cycle %0d, required no pending transaction", cyc);
        end else begin
            x = sb.pop_front();
            $display("txn %s: n_out=%0d d_out=%0d err=%b latency=%0d", x.tag, n_out, d_out, err, cyc);
            if (err !== 1'(x.er)) begin
                errors++;
                $display("FAIL %s err: got %b, required %0d", x.tag, err, x.er);
            end
            checks++;
            if (d_out !== N_W'(x.d)) begin
                errors++;
                $display("FAIL %s d_out: got %0d, required %0d", x.tag, d_out, x.d);
            end
            checks++;
            if (cyc != x.lat) begin
                errors++;
                $display("FAIL %s latency: got %0d, required %0d", x.tag, cyc, x.lat);
            end
            if (x.n_chk) begin
                checks++;
                if (n_out !== N_W'(x.n)) begin
                    errors++;
                    $display("FAIL %s n_out: got %0d, required %0d", x.tag, n_out, x.n);
                end
            end
        end
        if (poke) begin
            p = P_W'(13); q = P_W'(17); e = N_W'(5);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pulse_end: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic expect_quiet(input int cycles, input string tag);
        int pulses;
        pulses = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL %s quiet: %0d done pulses, required 0", tag, pulses);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b000 || n_out !== '0 || d_out !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b err=%b n=%0d d=%0d, required all 0",
                     busy, done, err, n_out, d_out);
        end
        $display("txn reset: outputs busy=%b done=%b err=%b n=%0d d=%0d", busy, done, err, n_out, d_out);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        push_const(3233, 2753, 0, 59 + VLAT, 1'b1, "p61q53e17");
        launch(61, 53, 17);
        sb_collect(1, 1'b0);
        push_const(33, 7, 0, 45 + VLAT, 1'b1, "p3q11e3");
        launch(3, 11, 3);
        sb_collect(1, 1'b0);
    endtask

    task automatic test_errors();
        push_const(35, 0, 1, 17, 1'b1, "p5q7e6_gcd");
        launch(5, 7, 6);
        sb_collect(1, 1'b0);
        push_const(0, 0, 1, 2, 1'b0, "p1q7e5");
        launch(1, 7, 5);
        sb_collect(1, 1'b0);
        push_const(0, 0, 1, 2, 1'b0, "p7q7e5");
        launch(7, 7, 5);
        sb_collect(1, 1'b0);
    endtask

    task automatic test_random();
        int primes [16] = '{5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61};
        int i, j, phi, ee;
        for (int r = 0; r < 6; r++) begin
            i = int'($urandom_range(0, 15));
            j = int'($urandom_range(0, 15));
            if (j == i) j = (i + 1) % 16;
            phi = (primes[i] - 1) * (primes[j] - 1);
            ee  = int'($urandom_range(2, phi - 1));
            sb.push_back(model(primes[i], primes[j], ee, $sformatf("rand%0d", r)));
            launch(primes[i], primes[j], ee);
            sb_collect(1, 1'b0);
        end
    endtask

    task automatic test_ignored_start();
        push_const(3233, 2753, 0, 59 + VLAT, 1'b1, "ignored_start");
        launch(61, 53, 17);
        repeat (19) @(negedge clk);
        p = P_W'(3); q = P_W'(11); e = N_W'(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sb_collect(21, 1'b0);
        expect_quiet(80, "ignored_start");
        checks++;
        if (n_out !== N_W'(3233) || d_out !== N_W'(2753)) begin
            errors++;
            $display("FAIL ignored_start hold: n=%0d d=%0d, required 3233 2753", n_out, d_out);
        end
    endtask

    task automatic test_reset_midop();
        push_const(3233, 2753, 0, 59 + VLAT, 1'b1, "aborted");
        launch(61, 53, 17);
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err} !== 3'b000 || n_out !== '0 || d_out !== '0) begin
            errors++;
            $display("FAIL midop_reset: busy=%b done=%b err=%b n=%0d d=%0d, required all 0",
                     busy, done, err, n_out, d_out);
        end
        $display("txn midop_reset: busy=%b n=%0d d=%0d", busy, n_out, d_out);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        expect_quiet(60, "after_reset");
        push_const(33, 7, 0, 45 + VLAT, 1'b1, "post_reset");
        launch(3, 11, 3);
        sb_collect(1, 1'b0);
    endtask

    task automatic test_back_to_back();
        push_const(3233, 2753, 0, 59 + VLAT, 1'b1, "start_on_done");
        launch(61, 53, 17);
        sb_collect(1, 1'b1);
        expect_quiet(40, "start_on_done");
        checks++;
        if (n_out !== N_W'(3233) || d_out !== N_W'(2753)) begin
            errors++;
            $display("FAIL start_on_done hold: n=%0d d=%0d, required 3233 2753", n_out, d_out);
        end
        sb.push_back(model(13, 17, 5, "b2b_a"));
        launch(13, 17, 5);
        sb_collect(1, 1'b0);
        sb.push_back(model(59, 47, 7, "b2b_b"));
        launch(59, 47, 7);
        sb_collect(1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_random();
        test_ignored_start();
        test_reset_midop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
